// File: rtl/sdram_burst_reader.sv
// Burst read sequencer: issues up to BURST_LEN word reads to a memory controller,
// bounds reads in flight to MAX_OUTSTANDING and forwards in-order returns one cycle later.
module sdram_burst_reader #(
  parameter int BURST_LEN       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk_sys_131_072,
  input  logic        reset,
  input  logic        rd,
  input  logic [24:0] rd_addr,
  input  logic        end_burst,
  output logic        data_available,
  output logic [15:0] data_out,
  output logic        busy,
  output logic        mem_req,
  output logic [24:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic        err_spurious
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [7:0] BURST_LEN_C = 8'(BURST_LEN);
  localparam logic [2:0] MAX_OUT_C   = 3'(MAX_OUTSTANDING);

  logic [1:0]  state_reg, state_next;
  logic [24:0] addr_reg, addr_next;
  logic [7:0]  issued_reg, issued_next;
  logic [2:0]  outstanding_reg, outstanding_next;
  logic        stop_reg, stop_next;
  logic        data_available_reg;
  logic [15:0] data_out_reg;
  logic        err_spurious_reg;
  logic        req_fire;
  logic        ret_fire;

  assign mem_req = (state_reg == ISSUE) && (issued_reg < BURST_LEN_C) &&
                   (outstanding_reg < MAX_OUT_C) && !stop_reg;
  assign req_fire = mem_req && mem_ack;
  // Returns with nothing in flight (e.g. after a reset mid-burst) are dropped.
  assign ret_fire = mem_rvalid && (outstanding_reg != 3'd0);

  assign mem_addr       = addr_reg;
  assign busy           = (state_reg != IDLE);
  assign data_available = data_available_reg;
  assign data_out       = data_out_reg;
  assign err_spurious   = err_spurious_reg;

  always_comb begin
    state_next       = state_reg;
    addr_next        = addr_reg;
    issued_next      = issued_reg;
    outstanding_next = outstanding_reg;
    stop_next        = stop_reg;

    if (req_fire) begin
      addr_next   = addr_reg + 25'd1;
      issued_next = issued_reg + 8'd1;
    end
    if (req_fire && !ret_fire) begin
      outstanding_next = outstanding_reg + 3'd1;
    end else if (!req_fire && ret_fire) begin
      outstanding_next = outstanding_reg - 3'd1;
    end

    case (state_reg)
      IDLE: begin
        if (rd) begin
          addr_next   = rd_addr;
          issued_next = 8'd0;
          stop_next   = 1'b0;
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        if (end_burst) begin
          stop_next = 1'b1;
        end
        if (stop_next || (issued_next == BURST_LEN_C)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding_reg == 3'd0) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_131_072) begin
    if (reset) begin
      state_reg          <= IDLE;
      addr_reg           <= '0;
      issued_reg         <= '0;
      outstanding_reg    <= '0;
      stop_reg           <= 1'b0;
      data_available_reg <= 1'b0;
      data_out_reg       <= '0;
      err_spurious_reg   <= 1'b0;
    end else begin
      state_reg          <= state_next;
      addr_reg           <= addr_next;
      issued_reg         <= issued_next;
      outstanding_reg    <= outstanding_next;
      stop_reg           <= stop_next;
      data_available_reg <= ret_fire;
      if (ret_fire) begin
        data_out_reg <= mem_rdata;
      end
      if (mem_rvalid && (outstanding_reg == 3'd0)) begin
        err_spurious_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_burst_reader.sv
// Randomized bench for sdram_burst_reader: a queue-based memory model returns
// words in order, and bursts are scored on addresses, request gating and returned data.
module tb_sdram_burst_reader;

  localparam int BURST_LEN = 16;
  localparam int MAX_OUT   = 4;

  logic        clk_sys_131_072 = 1'b0;
  logic        reset;
  logic        rd;
  logic [24:0] rd_addr;
  logic        end_burst;
  logic        data_available;
  logic [15:0] data_out;
  logic        busy;
  logic        mem_req;
  logic [24:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        err_spurious;

  always #5 clk_sys_131_072 = ~clk_sys_131_072;

  sdram_burst_reader #(.BURST_LEN(BURST_LEN), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk_sys_131_072(clk_sys_131_072),
    .reset(reset),
    .rd(rd),
    .rd_addr(rd_addr),
    .end_burst(end_burst),
    .data_available(data_available),
    .data_out(data_out),
    .busy(busy),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .err_spurious(err_spurious)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int          cyc = 0;
  int          ack_mode;      // 0 always, 1 every 4th cycle, 2 random
  int          ret_delay;
  int          stop_at;       // 0 = never pulse end_burst
  bit          inject_rd;
  bit          rd_injected;
  bit          in_burst = 1'b0;
  bit          stop_seen;
  logic [24:0] base_addr;
  int          n_acked, n_ret, n_strobe;
  logic        exp_err = 1'b0;
  logic [15:0] last_data = '0;
  int          ret_time_q[$];
  logic [24:0] ret_addr_q[$];
  logic [15:0] exp_data_q[$];

  function automatic logic [15:0] mem_word(input logic [24:0] a);
    return a[15:0] ^ {a[24:16], 7'h35} ^ 16'h5A3C;
  endfunction

  // One clock: observe the outputs produced by the last edge, then drive this cycle's inputs.
  task automatic step();
    logic        exp_req;
    logic [24:0] ea;
    logic [24:0] ra;
    @(posedge clk_sys_131_072);
    #1;
    cyc++;
    if (end_burst && in_burst) stop_seen = 1'b1;
    rd         = 1'b0;
    end_burst  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 16'($urandom);

    if (data_available) begin
      n_strobe++;
      if (exp_data_q.size() == 0) begin
        check_val("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        last_data = exp_data_q.pop_front();
        check_val("data_out", 32'(data_out), 32'(last_data));
      end
    end else begin
      check_val("data_hold", 32'(data_out), 32'(last_data));
    end
    check_val("err_spurious", 32'(err_spurious), 32'(exp_err));

    exp_req = in_burst && (n_acked < BURST_LEN) && ((n_acked - n_ret) < MAX_OUT) && !stop_seen;
    check_val("mem_req", 32'(mem_req), 32'(exp_req));

    case (ack_mode)
      0:       mem_ack = 1'b1;
      1:       mem_ack = (cyc % 4 == 0);
      default: mem_ack = 1'($urandom_range(0, 1));
    endcase

    if (mem_req && mem_ack) begin
      ea = base_addr + 25'(n_acked);
      check_val("mem_addr", 32'(mem_addr), 32'(ea));
      ret_time_q.push_back(cyc + ret_delay);
      ret_addr_q.push_back(ea);
      n_acked++;
      if (stop_at == n_acked) end_burst = 1'b1;
    end

    if (inject_rd && !rd_injected && n_acked >= 3 && in_burst) begin
      rd          = 1'b1;
      rd_addr     = 25'h5000;
      rd_injected = 1'b1;
    end

    if (ret_time_q.size() > 0 && ret_time_q[0] <= cyc) begin
      void'(ret_time_q.pop_front());
      ra         = ret_addr_q.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(ra);
      exp_data_q.push_back(mem_rdata);
      n_ret++;
    end
  endtask

  task automatic run_burst(input logic [24:0] addr, input int mode, input int delay,
                           input int stop_k, input bit inj);
    int guard;
    int exp_n;
    ack_mode    = mode;
    ret_delay   = delay;
    stop_at     = stop_k;
    inject_rd   = inj;
    rd_injected = 1'b0;
    stop_seen   = 1'b0;
    base_addr   = addr;
    n_acked     = 0;
    n_ret       = 0;
    n_strobe    = 0;
    rd          = 1'b1;
    rd_addr     = addr;
    in_burst    = 1'b1;
    step();
    check_val("busy_after_rd", 32'(busy), 32'd1);
    guard = 0;
    while (busy && guard < 3000) begin
      step();
      guard++;
    end
    check_val("burst_timeout", 32'(guard < 3000), 32'd1);
    in_burst = 1'b0;
    exp_n = (stop_k != 0) ? stop_k : BURST_LEN;
    check_val("request_count", 32'(n_acked), 32'(exp_n));
    check_val("strobe_count", 32'(n_strobe), 32'(exp_n));
    check_val("words_left", 32'(exp_data_q.size()), 32'd0);
    repeat (3) step();
    check_val("no_late_strobe", 32'(n_strobe), 32'(exp_n));
    $display("burst addr=0x%07h mode=%0d delay=%0d stop_at=%0d rd_inject=%0d reqs=%0d strobes=%0d",
             addr, mode, delay, stop_k, inj, n_acked, n_strobe);
  endtask

  task automatic reset_and_check(input string tag);
    reset      = 1'b1;
    rd         = 1'b1;           // reset must win over rd
    rd_addr    = 25'h0ABCDE;
    end_burst  = 1'b0;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    @(posedge clk_sys_131_072);
    #1;
    reset     = 1'b0;
    rd        = 1'b0;
    in_burst  = 1'b0;
    exp_err   = 1'b0;
    last_data = '0;
    ret_time_q.delete();
    ret_addr_q.delete();
    exp_data_q.delete();
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check_val({tag, "_data_available"}, 32'(data_available), 32'd0);
    check_val({tag, "_data_out"}, 32'(data_out), 32'd0);
    check_val({tag, "_err"}, 32'(err_spurious), 32'd0);
    $display("reset %s busy=%0d mem_req=%0d err=%0d", tag, busy, mem_req, err_spurious);
  endtask

  initial begin
    int guard;
    reset      = 1'b1;
    rd         = 1'b0;
    rd_addr    = '0;
    end_burst  = 1'b0;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    ack_mode   = 0;
    ret_delay  = 1;
    stop_at    = 0;
    repeat (3) @(posedge clk_sys_131_072);
    #1;
    reset_and_check("power_on");

    run_burst(25'h0000100, 0, 3, 0, 1'b0);
    run_burst(25'h0002000, 1, 10, 0, 1'b0);
    run_burst(25'h0000300, 0, 3, 5, 1'b0);
    run_burst(25'h1FFFFFE, 0, 2, 0, 1'b0);
    run_burst(25'h0000040, 2, 4, 0, 1'b1);
    run_burst(25'h0000041, 0, 1, 1, 1'b0);
    run_burst(25'h0000500, 0, 1, 16, 1'b0);

    // Reset mid-burst after three acks; the three late returns must be dropped.
    ack_mode  = 0;
    ret_delay = 1000;
    stop_at   = 0;
    inject_rd = 1'b0;
    stop_seen = 1'b0;
    base_addr = 25'h0000700;
    n_acked   = 0;
    n_ret     = 0;
    rd        = 1'b1;
    rd_addr   = base_addr;
    in_burst  = 1'b1;
    guard     = 0;
    while (n_acked < 3 && guard < 100) begin
      step();
      guard++;
    end
    check_val("reset_test_timeout", 32'(guard < 100), 32'd1);
    reset_and_check("mid_burst");
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 16'($urandom);
      @(posedge clk_sys_131_072);
      #1;
      mem_rvalid = 1'b0;
      check_val("spurious_dropped", 32'(data_available), 32'd0);
    end
    check_val("spurious_err_set", 32'(err_spurious), 32'd1);
    check_val("spurious_busy", 32'(busy), 32'd0);
    $display("spurious returns=3 data_available=%0d err=%0d busy=%0d", data_available, err_spurious, busy);
    reset_and_check("clear_err");

    for (int i = 0; i < 20; i++) begin
      run_burst(25'($urandom), $urandom_range(0, 2), $urandom_range(1, 12),
                ($urandom_range(0, 1) == 1) ? $urandom_range(1, BURST_LEN) : 0,
                1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_burst_reader.md
SDRAM_BURST_READER -- requirements
Module: sdram_burst_reader

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, max words issued per rd command (range 1..255).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, max accepted-but-unreturned memory reads (range 1..7).
REQ-003 SHALL have port clk_sys_131_072  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port rd  in  1  single-cycle burst start request.
REQ-006 SHALL have port rd_addr  in  25  word address of first word, sampled with rd.
REQ-007 SHALL have port end_burst  in  1  single-cycle request to stop issuing further words.
REQ-008 SHALL have port data_available  out  1  one-cycle strobe per returned word.
REQ-009 SHALL have port data_out  out  16  returned word, valid when data_available=1.
REQ-010 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-011 SHALL have port mem_req  out  1  word read request to memory controller.
REQ-012 SHALL have port mem_addr  out  25  word address for mem_req.
REQ-013 SHALL have port mem_ack  in  1  request accepted this cycle (valid only with mem_req=1).
REQ-014 SHALL have port mem_rvalid  in  1  read data return strobe, in order.
REQ-015 SHALL have port mem_rdata  in  16  read data, valid with mem_rvalid.
REQ-016 SHALL have port err_spurious  out  1  sticky flag, unexpected mem_rvalid seen.

Function
REQ-017 SHALL implement states IDLE, ISSUE, DRAIN.
REQ-018 IDLE: rd=1 -> latch rd_addr into addr counter, issued=0, stop=0, go ISSUE next cycle.
REQ-019 rd while busy=1 SHALL be ignored (no latch, no state change, no error).
REQ-020 end_burst in IDLE SHALL be ignored; rd and end_burst in same IDLE cycle -> burst starts, stop=0.
REQ-021 ISSUE: mem_req = (issued < BURST_LEN) && (outstanding < MAX_OUTSTANDING) && !stop; combinational from registered state.
REQ-022 mem_addr SHALL equal the addr counter; mem_req&&mem_ack -> addr+1 (wraps 0x1FFFFFF->0), issued+1, outstanding+1.
REQ-023 end_burst in ISSUE SHALL set stop from next cycle; a request acked in the same cycle as end_burst counts as issued.
REQ-024 ISSUE -> DRAIN when stop=1 or issued reaches BURST_LEN (evaluated on registered values after update).
REQ-025 DRAIN: mem_req=0; end_burst ignored; -> IDLE in the cycle after outstanding reaches 0.
REQ-026 mem_rvalid with outstanding>0 -> outstanding-1; next cycle data_available=1, data_out=mem_rdata (1-cycle latency).
REQ-027 ack and rvalid in same cycle -> outstanding unchanged; both events still take effect.
REQ-028 mem_rvalid with outstanding=0 -> word dropped (no data_available), err_spurious set until reset.
REQ-029 data_out SHALL hold its last value when data_available=0.
REQ-030 Burst completion SHALL be signalled only by data_available ceasing; no data_available strobes after entering IDLE until next rd.
REQ-031 issued counter 8 bits, outstanding counter 3 bits; neither SHALL overflow or underflow.

Reset
REQ-032 reset=1 -> state IDLE, busy=0, mem_req=0, data_available=0, data_out=0, err_spurious=0, issued=0, outstanding=0, stop=0, addr=0, regardless of state.
REQ-033 Reset mid-burst: in-flight returns arriving after reset SHALL follow REQ-028 (dropped, err_spurious=1).
REQ-034 reset has priority over rd in the same cycle.

Verification
REQ-035 Full burst: rd, rd_addr=0x000100, mem_ack always 1, rvalid 3 cycles after ack -> 16 requests addr 0x100..0x10F, 16 strobes in order, busy=0 after last.
REQ-036 Back-pressure: mem_ack=1 only every 4th cycle, rvalid delay 10 -> outstanding never >4, all 16 words returned in order.
REQ-037 Early stop: end_burst pulsed in cycle of 5th ack -> exactly 5 requests, 5 strobes, then IDLE.
REQ-038 Wrap: rd_addr=0x1FFFFFE, BURST_LEN=4 -> mem_addr 0x1FFFFFE, 0x1FFFFFF, 0x0000000, 0x0000001.
REQ-039 rd during ISSUE with rd_addr=0x5000 -> ignored; burst continues at original address; second rd after IDLE accepted.
REQ-040 Reset after 3 acks, 0 returns, then 3 rvalid -> no data_available, err_spurious=1, busy=0.
